uart_imem_loader: RTL and testbench

Boot-time program loader that sits directly upstream of the single-cycle CPU core's instruction fetch stage. It receives a program image over a UART 8N1 serial line, assembles little-endian 32-bit words, and writes them into instruction memory through a write port. It holds the CPU in reset for the whole load and releases it only when loading is finished and the load switch is off.

---
 rtl/uart_imem_loader_if.sv | 21 ++
 rtl/uart_imem_loader.sv | 214 +++++++++++++++++++++
 tb/tb_uart_imem_loader.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_imem_loader_if.sv
// Instruction-memory write port driven by the boot loader.
// One registered word write per imem_we pulse.
interface uart_imem_loader_if #(
  parameter int ADDR_WIDTH = 14
);
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;

  modport master (
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

  modport slave (
    input imem_we,
    input imem_addr,
    input imem_wdata
  );
endinterface

// File: rtl/uart_imem_loader.sv
// UART 8N1 boot loader: receives a counted little-endian image
// and writes it into instruction memory, holding the CPU in reset.
module uart_imem_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_WIDTH   = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx,
  input  logic                   load_en,
  uart_imem_loader_if.master     imem,
  output logic                   cpu_rst_n,
  output logic                   done,
  output logic                   frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_st_t;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    DATA,
    DONE
  } ld_st_t;

  logic          r_rx_s1;
  logic          r_rx_s2;
  rx_st_t        r_rx_st;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_byte_valid;
  logic          r_byte_err;

  ld_st_t                r_ld_st;
  logic [15:0]           r_n;
  logic [15:0]           r_wcnt;
  logic [ADDR_WIDTH-1:0] r_widx;
  logic [1:0]            r_bidx;
  logic [31:0]           r_word;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic                  r_cpu_rst_n;
  logic                  r_done;
  logic                  r_ferr;

  logic [31:0] w_word_next;
  logic        w_loading;

  assign w_word_next = {r_shift, r_word[31:8]};
  assign w_loading   = (r_ld_st == HDR0) ||
                       (r_ld_st == HDR1) ||
                       (r_ld_st == DATA);

  assign imem.imem_we    = r_we;
  assign imem.imem_addr  = r_addr;
  assign imem.imem_wdata = r_wdata;
  assign cpu_rst_n       = r_cpu_rst_n;
  assign done            = r_done;
  assign frame_err       = r_ferr;

  // Two-flop synchronizer for the asynchronous serial line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
    end
  end

  // UART receiver: mid-bit sampling, glitch reject, stop check
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_st      <= RX_IDLE;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
      r_byte_err   <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_byte_err   <= 1'b0;
      unique case (r_rx_st)
        RX_IDLE: begin
          r_cnt <= '0;
          r_bit <= '0;
          if (!r_rx_s2) r_rx_st <= RX_START;
        end
        RX_START: begin
          if (r_cnt == HALF_M1) begin
            r_cnt   <= '0;
            r_rx_st <= r_rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_cnt == FULL_M1) begin
            r_cnt   <= '0;
            r_shift <= {r_rx_s2, r_shift[7:1]};
            r_bit   <= r_bit + 1'b1;
            if (r_bit == 3'd7) r_rx_st <= RX_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_cnt == FULL_M1) begin
            r_cnt   <= '0;
            r_rx_st <= RX_IDLE;
            if (r_rx_s2) r_byte_valid <= 1'b1;
            else         r_byte_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_rx_st <= RX_IDLE;
      endcase
    end
  end

  // Load sequencer: header, word assembly, writes, CPU reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ld_st     <= IDLE;
      r_n         <= '0;
      r_wcnt      <= '0;
      r_widx      <= '0;
      r_bidx      <= '0;
      r_word      <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_rst_n <= 1'b0;
      r_done      <= 1'b0;
      r_ferr      <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (w_loading && !load_en) begin
        r_ld_st     <= IDLE;
        r_cpu_rst_n <= 1'b1;
      end else if (w_loading && r_byte_err) begin
        r_ferr  <= 1'b1;
        r_ld_st <= DONE;
      end else begin
        unique case (r_ld_st)
          IDLE: begin
            if (load_en) begin
              r_ld_st     <= HDR0;
              r_cpu_rst_n <= 1'b0;
              r_done      <= 1'b0;
              r_ferr      <= 1'b0;
              r_wcnt      <= '0;
              r_widx      <= '0;
              r_bidx      <= '0;
            end else begin
              r_cpu_rst_n <= 1'b1;
            end
          end
          HDR0: begin
            if (r_byte_valid) begin
              r_n[7:0] <= r_shift;
              r_ld_st  <= HDR1;
            end
          end
          HDR1: begin
            if (r_byte_valid) begin
              r_n[15:8] <= r_shift;
              if ({r_shift, r_n[7:0]} == 16'd0) r_ld_st <= DONE;
              else                              r_ld_st <= DATA;
            end
          end
          DATA: begin
            if (r_byte_valid) begin
              r_word <= w_word_next;
              r_bidx <= r_bidx + 1'b1;
              if (r_bidx == 2'd3) begin
                r_we    <= 1'b1;
                r_addr  <= r_widx;
                r_wdata <= w_word_next;
                r_widx  <= r_widx + 1'b1;
                r_wcnt  <= r_wcnt + 1'b1;
                if (r_wcnt == r_n - 16'd1) r_ld_st <= DONE;
              end
            end
          end
          DONE: begin
            if (!load_en) begin
              r_ld_st     <= IDLE;
              r_cpu_rst_n <= 1'b1;
            end else if (!r_ferr) begin
              r_done <= 1'b1;
            end
          end
          default: r_ld_st <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_imem_loader.sv
// Scoreboard bench for uart_imem_loader: directed UART images,
// expected memory writes queued and checked by a monitor.
module tb_uart_imem_loader;

  localparam int CPB = 8;
  localparam int AW  = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx  = 1'b1;
  logic load_en = 1'b0;
  logic cpu_rst_n, done, frame_err;

  uart_imem_loader_if #(.ADDR_WIDTH(AW)) imem ();

  uart_imem_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_WIDTH  (AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .load_en  (load_en),
    .imem     (imem.master),
    .cpu_rst_n(cpu_rst_n),
    .done     (done),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the head of the queue
  always @(negedge clk) begin
    if (imem.imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_we: addr %h data %h",
                 imem.imem_addr, imem.imem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        n_cmp++;
        if (imem.imem_addr !== e.addr || imem.imem_wdata !== e.data) begin
          n_bad++;
          $display("FAIL write: got %h@%h expected %h@%h",
                   imem.imem_wdata, imem.imem_addr, e.data, e.addr);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cyc(CPB);
    end
    rx = stop;
    cyc(CPB);
    rx = 1'b1;
    cyc(2 * CPB);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic expect_wr(input logic [AW-1:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string nm);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      cyc(1);
      k++;
    end
    check(nm, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    // Reset and idle
    cyc(5);
    check("rst_we", {31'd0, imem.imem_we}, 32'd0);
    check("rst_addr", 32'(imem.imem_addr), 32'd0);
    check("rst_wdata", imem.imem_wdata, 32'd0);
    check("rst_cpu", {31'd0, cpu_rst_n}, 32'd0);
    check("rst_flags", {30'd0, done, frame_err}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cyc(1);
    check("cpu_release", {31'd0, cpu_rst_n}, 32'd1);
    cyc(5);

    // Basic two-word load
    load_en = 1'b1;
    cyc(1);
    check("load_cpu_hold", {31'd0, cpu_rst_n}, 32'd0);
    expect_wr(2'd0, 32'h00A00513);
    expect_wr(2'd1, 32'h00100593);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_word(32'h00A00513);
    send_word(32'h00100593);
    drain("basic_drain");
    cyc(4);
    check("basic_done", {31'd0, done}, 32'd1);
    check("basic_cpu_held", {31'd0, cpu_rst_n}, 32'd0);
    load_en = 1'b0;
    cyc(2);
    check("basic_cpu_run", {31'd0, cpu_rst_n}, 32'd1);

    // Glitch rejected, then empty image
    load_en = 1'b1;
    cyc(2);
    rx = 1'b0;
    cyc(2);
    rx = 1'b1;
    cyc(3 * CPB);
    check("glitch_nodone", {31'd0, done}, 32'd0);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    cyc(4);
    check("n0_done", {31'd0, done}, 32'd1);
    load_en = 1'b0;
    cyc(2);

    // Frame error
    load_en = 1'b1;
    cyc(2);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hAA, 1'b0);
    cyc(4);
    check("ferr_set", {31'd0, frame_err}, 32'd1);
    check("ferr_nodone", {31'd0, done}, 32'd0);
    check("ferr_cpu_held", {31'd0, cpu_rst_n}, 32'd0);
    load_en = 1'b0;
    cyc(2);
    check("ferr_cpu_run", {31'd0, cpu_rst_n}, 32'd1);
    load_en = 1'b1;
    cyc(2);
    check("ferr_clear", {31'd0, frame_err}, 32'd0);
    load_en = 1'b0;
    cyc(2);

    // Abort mid-word, then wrapping reload
    load_en = 1'b1;
    cyc(2);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    load_en = 1'b0;
    cyc(2);
    check("abort_cpu_run", {31'd0, cpu_rst_n}, 32'd1);
    check("abort_nodone", {31'd0, done}, 32'd0);
    load_en = 1'b1;
    cyc(2);
    expect_wr(2'd0, 32'hDEADBEEF);
    expect_wr(2'd1, 32'h01234567);
    expect_wr(2'd2, 32'h89ABCDEF);
    expect_wr(2'd3, 32'hCAFEF00D);
    expect_wr(2'd0, 32'h0BADC0DE);
    send_byte(8'h05, 1'b1);
    send_byte(8'h00, 1'b1);
    send_word(32'hDEADBEEF);
    send_word(32'h01234567);
    send_word(32'h89ABCDEF);
    send_word(32'hCAFEF00D);
    send_word(32'h0BADC0DE);
    drain("wrap_drain");
    cyc(4);
    check("wrap_done", {31'd0, done}, 32'd1);
    load_en = 1'b0;
    cyc(2);

    // Async reset during the third data byte
    load_en = 1'b1;
    cyc(2);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h44, 1'b1);
    send_byte(8'h55, 1'b1);
    rx = 1'b0;
    cyc(CPB * 3);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("arst_cpu", {31'd0, cpu_rst_n}, 32'd0);
    check("arst_we", {31'd0, imem.imem_we}, 32'd0);
    check("arst_flags", {30'd0, done, frame_err}, 32'd0);
    rx = 1'b1;
    cyc(3 * CPB);
    @(negedge clk);
    rst = 1'b1;
    cyc(2);
    expect_wr(2'd0, 32'h04030201);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_word(32'h04030201);
    drain("arst_drain");
    cyc(4);
    check("arst_done", {31'd0, done}, 32'd1);
    load_en = 1'b0;
    cyc(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
